// File: rtl/vc_weighted_arbiter.sv
// vc_weighted_arbiter
// -------------------
// Weighted round-robin scheduler sharing one transaction-layer output path
// between NUM_REQ virtual-channel FIFOs. It arbitrates only while `active`
// is high. Once a VC is granted, its FIFO head is popped in a burst of up to
// weight[vc] words. A SELECT cycle separates consecutive grants.
//
// Handshake: a word leaves VC i on a cycle where fifo_pop[i]=1. fifo_pop is
// only raised when fifo_empty[i]=0, so pop acts as "ready" against the FIFO's
// implicit "valid" (~fifo_empty). out_valid has no ready. The destination
// throttles the arbiter through dest_almost_full, which holds off further
// pops.
//
// Optional build macro: VC_ARB_GRANT_COUNT_EN adds per-VC saturating 8-bit
// pop counters on grant_count.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   init              one-cycle pulse: latch weight_cfg, restart arbitration
//   active            arbitration enable from the link state machine
//   weight_cfg        per-VC burst weights, VC i at [i*WEIGHT_W +: WEIGHT_W]
//   fifo_empty        per-VC empty flags
//   fifo_data         show-ahead head words, VC i at [i*DATA_W +: DATA_W]
//   fifo_pop          one-hot combinational pop strobe
//   dest_almost_full  destination backpressure
//   out_valid/out_data/out_vc  registered popped word and its source VC
//   busy              high while a burst is being served
//   grant_count       (VC_ARB_GRANT_COUNT_EN only) per-VC pop counters
module vc_weighted_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 6,
  parameter int WEIGHT_W = 3,
  parameter int ID_W     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic                         active,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_cfg,
  input  logic [NUM_REQ-1:0]           fifo_empty,
  input  logic [NUM_REQ*DATA_W-1:0]    fifo_data,
  output logic [NUM_REQ-1:0]           fifo_pop,
  input  logic                         dest_almost_full,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [ID_W-1:0]              out_vc,
  output logic                         busy
`ifdef VC_ARB_GRANT_COUNT_EN
  ,
  output logic [NUM_REQ*8-1:0]         grant_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

  // state_q is the FSM state that checkers bind to.
  state_t              state_q;
  state_t              state_d;

  logic [WEIGHT_W-1:0] weight_q [NUM_REQ];
  logic [WEIGHT_W-1:0] cfg_w    [NUM_REQ];
  logic [DATA_W-1:0]   head_w   [NUM_REQ];
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     grant_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic [ID_W-1:0]     sel_id;
  logic                sel_found;
  logic                pop_ok;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign cfg_w[gi]  = weight_cfg[gi*WEIGHT_W +: WEIGHT_W];
    assign head_w[gi] = fifo_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin search starting just after the last grant. A zero weight
  // masks a VC. The offset ordering makes ptr+1 the highest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found
          && !fifo_empty[ID_W'((int'(ptr_q) + k) % NUM_REQ)]
          && weight_q[ID_W'((int'(ptr_q) + k) % NUM_REQ)] != '0) begin
        sel_found = 1'b1;
        sel_id    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // reset and init also gate the pop so nothing leaves the FIFO in the
  // cycle the arbiter is being restarted.
  assign pop_ok = (state_q == ST_BURST) && active && !init && !reset
                  && !fifo_empty[grant_q] && !dest_almost_full
                  && (credit_q != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (active) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (!active)        state_d = ST_IDLE;
        else if (sel_found) state_d = ST_BURST;
      end
      ST_BURST: begin
        // An empty FIFO ends the burst even while the destination stalls.
        if (!active)                                   state_d = ST_IDLE;
        else if (fifo_empty[grant_q])                  state_d = ST_SELECT;
        else if (credit_q == '0)                       state_d = ST_SELECT;
        else if (pop_ok && credit_q == WEIGHT_W'(1))   state_d = ST_SELECT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (init) state_d = ST_IDLE;
  end

  // Outputs
  always_comb begin
    fifo_pop = '0;
    if (pop_ok) fifo_pop[grant_q] = 1'b1;
    busy = (state_q == ST_BURST);
  end

  // Datapath: weights, round-robin pointer, burst credit, output register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) weight_q[i] <= WEIGHT_W'(1);
      ptr_q     <= ID_W'(NUM_REQ - 1);
      grant_q   <= '0;
      credit_q  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_vc    <= '0;
    end else if (init) begin
      for (int i = 0; i < NUM_REQ; i++) weight_q[i] <= cfg_w[i];
      ptr_q     <= ID_W'(NUM_REQ - 1);
      credit_q  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pop_ok;
      if (pop_ok) begin
        out_data <= head_w[grant_q];
        out_vc   <= grant_q;
        credit_q <= credit_q - WEIGHT_W'(1);
      end
      if (state_q == ST_SELECT && active && sel_found) begin
        grant_q  <= sel_id;
        ptr_q    <= sel_id;
        credit_q <= weight_q[sel_id];
      end
      // Dropping out of the link-active state abandons the burst.
      if (state_q == ST_BURST && !active) credit_q <= '0;
    end
  end

`ifdef VC_ARB_GRANT_COUNT_EN
  logic [7:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset || init) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fifo_pop[i] && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
      end
    end
  end

  for (genvar gc = 0; gc < NUM_REQ; gc++) begin : g_cnt
    assign grant_count[gc*8 +: 8] = cnt_q[gc];
  end
`endif

endmodule

// File: tb/tb_vc_weighted_arbiter.sv
// Bench for vc_weighted_arbiter. Bench-side FIFOs feed the DUT. A behavioural
// scheduler model predicts pops and outputs every cycle, and directed
// scenarios pin the model with hand-computed grant sequences.
module tb_vc_weighted_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 6;
  localparam int WEIGHT_W = 3;
  localparam int ID_W     = 2;
  localparam int DEPTH    = 64;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        init;
  logic                        active;
  logic [NUM_REQ*WEIGHT_W-1:0] weight_cfg;
  logic [NUM_REQ-1:0]          fifo_empty;
  logic [NUM_REQ*DATA_W-1:0]   fifo_data;
  logic [NUM_REQ-1:0]          fifo_pop;
  logic                        dest_almost_full;
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [ID_W-1:0]             out_vc;
  logic                        busy;
`ifdef VC_ARB_GRANT_COUNT_EN
  logic [NUM_REQ*8-1:0]        grant_count;
`endif

  vc_weighted_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .active(active),
    .weight_cfg(weight_cfg), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .dest_almost_full(dest_almost_full),
    .out_valid(out_valid), .out_data(out_data), .out_vc(out_vc), .busy(busy)
`ifdef VC_ARB_GRANT_COUNT_EN
    , .grant_count(grant_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench FIFOs ----------------
  logic [DATA_W-1:0] mem [NUM_REQ][DEPTH];
  int                rd [NUM_REQ];
  int                wr [NUM_REQ];
  logic [NUM_REQ-1:0] pop_now = '0;

  function automatic int vc_size(input int v);
    return wr[v] - rd[v];
  endfunction

  // Applies the pops seen last cycle, then presents the new heads.
  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin rd[i] = 0; wr[i] = 0; end
    fifo_empty = '1;
    fifo_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++)
        if (pop_now[i] && vc_size(i) > 0) rd[i]++;
      for (int i = 0; i < NUM_REQ; i++) begin
        fifo_empty[i] = (vc_size(i) == 0);
        fifo_data[i*DATA_W +: DATA_W] = (vc_size(i) == 0) ? '0 : mem[i][rd[i]];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];     // {vc, data} of every word the model popped
  int pop_log[$];           // VC of every DUT pop, in order
  int pop_cyc[$];           // cycle number of every DUT pop
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  // m_phase: 0 = waiting for active, 1 = looking for a VC, 2 = serving m_owner
  logic [WEIGHT_W-1:0] m_w [NUM_REQ];
  int   m_cnt [NUM_REQ];
  int   m_phase, m_owner, m_ptr, m_credit;
  bit   m_popped;
  logic [NUM_REQ-1:0] exp_pop;

  initial begin
    bit   found;
    int   g;
    logic [7:0] e;
    for (int i = 0; i < NUM_REQ; i++) begin m_w[i] = 1; m_cnt[i] = 0; end
    m_phase = 0; m_owner = 0; m_ptr = NUM_REQ - 1; m_credit = 0; m_popped = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      exp_pop = '0;
      if (!reset && !init && m_phase == 2 && active && vc_size(m_owner) > 0
          && !dest_almost_full && m_credit > 0)
        exp_pop[m_owner] = 1'b1;

      check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
      check("busy", 32'(busy), 32'(m_phase == 2));
      check("out_valid", 32'(out_valid), 32'(m_popped));
      if (m_popped && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_vc", 32'(out_vc), 32'(e[7:6]));
        check("out_data", 32'(out_data), 32'(e[5:0]));
      end
`ifdef VC_ARB_GRANT_COUNT_EN
      for (int i = 0; i < NUM_REQ; i++)
        check("grant_count", 32'(grant_count[i*8 +: 8]), 32'(m_cnt[i]));
`endif

      pop_now = fifo_pop;
      for (int i = 0; i < NUM_REQ; i++)
        if (fifo_pop[i]) begin pop_log.push_back(i); pop_cyc.push_back(cyc); end

      // advance the model by one cycle
      m_popped = (exp_pop != '0);
      if (reset) begin
        for (int i = 0; i < NUM_REQ; i++) begin m_w[i] = 1; m_cnt[i] = 0; end
        m_phase = 0; m_ptr = NUM_REQ - 1; m_credit = 0;
        exp_q.delete();
      end else if (init) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          m_w[i] = weight_cfg[i*WEIGHT_W +: WEIGHT_W];
          m_cnt[i] = 0;
        end
        m_phase = 0; m_ptr = NUM_REQ - 1; m_credit = 0;
      end else begin
        if (m_popped) begin
          exp_q.push_back({2'(m_owner), mem[m_owner][rd[m_owner]]});
          if (m_cnt[m_owner] < 255) m_cnt[m_owner]++;
          m_credit--;
        end
        case (m_phase)
          0: if (active) m_phase = 1;
          1: begin
            if (!active) m_phase = 0;
            else begin
              found = 0;
              for (int k = 1; k <= NUM_REQ; k++) begin
                g = (m_ptr + k) % NUM_REQ;
                if (!found && vc_size(g) > 0 && m_w[g] != 0) begin
                  found = 1; m_owner = g; m_ptr = g; m_credit = int'(m_w[g]); m_phase = 2;
                end
              end
            end
          end
          default: begin
            if (!active) begin m_phase = 0; m_credit = 0; end
            else if (vc_size(m_owner) == 0) m_phase = 1;
            else if (m_popped && m_credit == 0) m_phase = 1;
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int vc, input int n);
    for (int j = 0; j < n; j++)
      if (wr[vc] < DEPTH) begin
        mem[vc][wr[vc]] = DATA_W'($urandom_range(0, 63));
        wr[vc]++;
      end
  endtask

  task automatic do_init(input logic [NUM_REQ*WEIGHT_W-1:0] cfg);
    weight_cfg = cfg;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic flush();
    tick();
    active = 1'b0;
    dest_almost_full = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NUM_REQ; i++) begin rd[i] = 0; wr[i] = 0; end
    pop_log.delete();
    pop_cyc.delete();
    tick();
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k;
    k = 0;
    while (pop_log.size() < n && k < budget) begin @(negedge clk); k++; end
    check("pop_budget", 32'(pop_log.size() >= n), 32'd1);
  endtask

  task automatic wait_pop0(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!fifo_pop[0] && k < budget) begin @(negedge clk); k++; end
    check("pop0_budget", 32'(fifo_pop[0]), 32'd1);
  endtask

  task automatic check_log(input string name, input int idx, input int exp);
    check(name, (idx < pop_log.size()) ? 32'(pop_log[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic check_gap(input string name, input int idx, input int exp);
    check(name, (idx + 1 < pop_cyc.size()) ? 32'(pop_cyc[idx+1] - pop_cyc[idx]) : 32'hFFFF_FFFF,
          32'(exp));
  endtask

  // ---------------- directed scenarios ----------------
  int seq2 [12] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};

  initial begin
    reset = 1'b1; init = 1'b0; active = 1'b0; dest_almost_full = 1'b0;
    weight_cfg = '0;
    #1;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_vc", 32'(out_vc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_pop", 32'(fifo_pop), 32'd0);
    reset = 1'b0;
    tick();

    // Equal weights: one pop per grant, SELECT cycle between grants.
    do_init({3'd1, 3'd1, 3'd1, 3'd1});
    for (int i = 0; i < NUM_REQ; i++) push(i, 4);
    active = 1'b1;
    wait_pops(5, 40);
    check_log("rr_order0", 0, 0);
    check_log("rr_order1", 1, 1);
    check_log("rr_order2", 2, 2);
    check_log("rr_order3", 3, 3);
    check_log("rr_order4", 4, 0);
    for (int i = 0; i < 4; i++) check_gap("rr_gap", i, 2);
    flush();

    // Weights 3,1,0,2: VC2 masked; late weight_cfg change ignored.
    do_init({3'd2, 3'd0, 3'd1, 3'd3});
    for (int i = 0; i < NUM_REQ; i++) push(i, 10);
    active = 1'b1;
    tick(); tick();
    weight_cfg = {3'd7, 3'd7, 3'd7, 3'd7};
    wait_pops(12, 80);
    for (int i = 0; i < 12; i++) check_log("wrr_seq", i, seq2[i]);
    flush();

    // VC0 runs dry with credit left: grant moves on to VC1.
    do_init({3'd1, 3'd1, 3'd1, 3'd3});
    push(0, 2);
    push(1, 1);
    active = 1'b1;
    wait_pops(3, 30);
    repeat (6) tick();
    check("dry_pop_total", 32'(pop_log.size()), 32'd3);
    check_log("dry_seq0", 0, 0);
    check_log("dry_seq1", 1, 0);
    check_log("dry_seq2", 2, 1);
    check_gap("dry_gap0", 0, 1);
    check_gap("dry_gap1", 1, 3);
    flush();

    // Destination stall for 4 cycles mid-burst.
    do_init({3'd1, 3'd1, 3'd1, 3'd4});
    push(0, 8);
    push(1, 2);
    active = 1'b1;
    wait_pop0(20);
    @(posedge clk); #1;
    dest_almost_full = 1'b1;
    repeat (4) tick();
    dest_almost_full = 1'b0;
    wait_pops(5, 30);
    check_log("stall_seq0", 0, 0);
    check_log("stall_seq3", 3, 0);
    check_log("stall_seq4", 4, 1);
    check_gap("stall_gap0", 0, 5);
    check_gap("stall_gap1", 1, 1);
    flush();

    // active drops mid-burst, then reset together with init.
    do_init({3'd1, 3'd1, 3'd1, 3'd4});
    push(0, 6);
    push(1, 3);
    active = 1'b1;
    wait_pop0(20);
    @(posedge clk); #1;
    active = 1'b0;
    tick(); tick();
    active = 1'b1;
    reset = 1'b1;
    init = 1'b1;
    weight_cfg = {3'd2, 3'd2, 3'd2, 3'd2};
    tick();
    check("rstinit_busy", 32'(busy), 32'd0);
    check("rstinit_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    init = 1'b0;
    pop_log.delete();
    pop_cyc.delete();
    wait_pops(2, 20);
    check_log("rstinit_seq0", 0, 0);
    check_log("rstinit_seq1", 1, 1);
    flush();

    // All FIFOs empty, then only VC2 fills: search wraps from VC3 to VC2.
    do_init({3'd1, 3'd1, 3'd1, 3'd1});
    active = 1'b1;
    repeat (6) tick();
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_no_pops", 32'(pop_log.size()), 32'd0);
    push(2, 2);
    wait_pops(2, 20);
    check_log("wrap_seq0", 0, 2);
    check_log("wrap_seq1", 1, 2);
`ifdef VC_ARB_GRANT_COUNT_EN
    tick();
    check("grant_count_vc2", 32'(grant_count[2*8 +: 8]), 32'd2);
    check("grant_count_vc0", 32'(grant_count[0 +: 8]), 32'd0);
`endif
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
